// File: rtl/ifq_pkg.sv
// Shared constants and the queue entry type for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned IfqAddrWidth = 32;
  localparam int unsigned IfqDatWidth  = 32;
  localparam int unsigned IfqDepth     = 4;
  localparam int unsigned IfqMaxOut    = 2;
  localparam logic [31:0] IfqResetPc   = 32'h0000_0000;
  localparam logic [31:0] NopInstr     = 32'h0000_0013;

  typedef struct packed {
    logic [IfqAddrWidth-1:0] pc;
    logic [IfqDatWidth-1:0]  instr;
    logic                    alloc;
    logic                    filled;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_ring.sv
// Circular entry store: allocate at tail in PC order, fill in the same order, pop at head.
module ifq_ring
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = IfqDepth,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [IfqAddrWidth-1:0] push_pc_i,
  input  logic                    fill_i,
  input  logic [IfqDatWidth-1:0]  fill_data_i,
  input  logic                    pop_i,
  output ifq_entry_t              head_o,
  output logic [CntW-1:0]         count_o
);

  ifq_entry_t      ent_q [DEPTH];
  ifq_entry_t      ent_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else begin
      if (pop_i) begin
        ent_d[head_q].alloc  = 1'b0;
        ent_d[head_q].filled = 1'b0;
        head_d               = head_q + 1'b1;
      end
      // The fill pointer always trails the tail at the oldest unfilled allocation.
      if (fill_i) begin
        ent_d[fill_q].instr  = fill_data_i;
        ent_d[fill_q].filled = 1'b1;
        fill_d               = fill_q + 1'b1;
      end
      if (push_i) begin
        ent_d[tail_q].pc     = push_pc_i;
        ent_d[tail_q].instr  = '0;
        ent_d[tail_q].alloc  = 1'b1;
        ent_d[tail_q].filled = 1'b0;
        tail_d               = tail_q + 1'b1;
      end
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

  assign head_o  = ent_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction fetch: issues in-order memory requests, buffers responses and
// presents the oldest fetched instruction to decode from registers only.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = IfqAddrWidth,
  parameter int unsigned           DAT_WIDTH  = IfqDatWidth,
  parameter int unsigned           DEPTH      = IfqDepth,
  parameter int unsigned           MAX_OUT    = IfqMaxOut,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = IfqResetPc
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc_E,
  input  logic [ADDR_WIDTH-1:0] PCTarget_E,
  input  logic                  PC_Write,
  input  logic                  IF_ID_Write,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DAT_WIDTH-1:0]  imem_rsp_data,
  output logic                  valid_D,
  output logic [DAT_WIDTH-1:0]  Ins_D,
  output logic [ADDR_WIDTH-1:0] PC_D,
  output logic [ADDR_WIDTH-1:0] PC_4D
);

  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if ((ADDR_WIDTH != IfqAddrWidth) || (DAT_WIDTH != IfqDatWidth)) begin : g_bad_width
    $error("ifetch_queue: entry struct is sized for the package default widths");
  end

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [OutW-1:0]       out_q, out_d;
  logic [OutW-1:0]       drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] pc_hold_q, pc_hold_d;
  logic [ADDR_WIDTH-1:0] pc4_hold_q, pc4_hold_d;

  ifq_entry_t      head;
  logic [CntW-1:0] count;
  logic            req_fire, rsp_take, fill, pop;
  logic            unused_tgt;

  assign unused_tgt = ^PCTarget_E[1:0];

  assign imem_req_valid = !rst && PC_Write && !PCSrc_E &&
                          (count < CntW'(DEPTH)) && (out_q < OutW'(MAX_OUT));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is only meaningful while something is outstanding; this keeps counters >= 0.
  assign rsp_take = !rst && imem_rsp_valid && (out_q != '0);
  assign fill     = rsp_take && (drop_q == '0) && !PCSrc_E;

  assign valid_D  = !rst && head.alloc && head.filled;
  assign pop      = valid_D && IF_ID_Write && !PCSrc_E;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    if (PCSrc_E) begin
      fetch_pc_d = {PCTarget_E[ADDR_WIDTH-1:2], 2'b00};
      // Everything still in flight belongs to the old path and must be discarded.
      out_d      = out_q - OutW'(rsp_take);
      drop_d     = out_q - OutW'(rsp_take);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      out_d = out_q + OutW'(req_fire) - OutW'(rsp_take);
      if (rsp_take && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
    end
  end

  always_comb begin
    pc_hold_d  = pc_hold_q;
    pc4_hold_d = pc4_hold_q;
    if (valid_D) begin
      pc_hold_d  = head.pc;
      pc4_hold_d = head.pc + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      pc_hold_q  <= '0;
      pc4_hold_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      pc_hold_q  <= pc_hold_d;
      pc4_hold_q <= pc4_hold_d;
    end
  end

  ifq_ring #(
    .DEPTH(DEPTH)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (PCSrc_E),
    .push_i     (req_fire),
    .push_pc_i  (fetch_pc_q),
    .fill_i     (fill),
    .fill_data_i(imem_rsp_data),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign Ins_D = valid_D ? head.instr : DAT_WIDTH'(NopInstr);
  assign PC_D  = rst ? '0 : (valid_D ? head.pc : pc_hold_q);
  assign PC_4D = rst ? '0 : (valid_D ? head.pc + ADDR_WIDTH'(4) : pc4_hold_q);

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a queue-level model of the fetch rules.
module tb_ifetch_queue;

  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk, rst, PCSrc_E, PC_Write, IF_ID_Write;
  logic [31:0] PCTarget_E;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        valid_D;
  logic [31:0] Ins_D, PC_D, PC_4D;

  ifetch_queue #(
    .ADDR_WIDTH(32),
    .DAT_WIDTH (32),
    .DEPTH     (DEPTH),
    .MAX_OUT   (MAX_OUT),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrc_E       (PCSrc_E),
    .PCTarget_E    (PCTarget_E),
    .PC_Write      (PC_Write),
    .IF_ID_Write   (IF_ID_Write),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .valid_D       (valid_D),
    .Ins_D         (Ins_D),
    .PC_D          (PC_D),
    .PC_4D         (PC_4D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } mentry_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  mentry_t     mq[$];
  mreq_t       pend[$];
  int          m_out, m_drop, cyc, lat, total, bad;
  logic [31:0] m_fetch, m_last_pc, m_last_pc4;
  bit          o_req, o_vd;
  logic [31:0] o_addr, o_ins, o_pcd, o_pc4;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_out      = 0;
    m_drop     = 0;
    m_fetch    = 32'h0;
    m_last_pc  = 32'h0;
    m_last_pc4 = 32'h0;
  endtask

  // One clock: memory drives its response, outputs are checked mid-cycle, model steps at the edge.
  task automatic run_cycle();
    bit      exp_req, exp_vd, take;
    mentry_t e;
    if (rst) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    exp_req = !rst && PC_Write && !PCSrc_E && (mq.size() < DEPTH) && (m_out < MAX_OUT);
    exp_vd  = !rst && (mq.size() > 0) && mq[0].filled;
    @(negedge clk);
    o_req = imem_req_valid; o_addr = imem_req_addr; o_vd = valid_D;
    o_ins = Ins_D; o_pcd = PC_D; o_pc4 = PC_4D;
    total++;
    if (o_req !== exp_req) begin
      bad++; $display("FAIL req_valid cyc=%0d got=%0b want=%0b", cyc, o_req, exp_req);
    end
    if (exp_req) begin
      total++;
      if (o_addr !== m_fetch) begin
        bad++; $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, o_addr, m_fetch);
      end
    end
    total++;
    if (o_vd !== exp_vd) begin
      bad++; $display("FAIL valid_D cyc=%0d got=%0b want=%0b", cyc, o_vd, exp_vd);
    end
    total++;
    if (exp_vd) begin
      if (o_ins !== mq[0].instr || o_pcd !== mq[0].pc || o_pc4 !== mq[0].pc + 32'd4) begin
        bad++;
        $display("FAIL head cyc=%0d got ins=%h pc=%h pc4=%h want ins=%h pc=%h", cyc, o_ins,
                 o_pcd, o_pc4, mq[0].instr, mq[0].pc);
      end
    end else begin
      if (o_ins !== NOP || o_pcd !== (rst ? 32'h0 : m_last_pc) ||
          o_pc4 !== (rst ? 32'h0 : m_last_pc4)) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d got ins=%h pc=%h pc4=%h want pc=%h", cyc, o_ins,
                 o_pcd, o_pc4, rst ? 32'h0 : m_last_pc);
      end
    end
    @(posedge clk);
    if (!rst && o_req && imem_req_ready) pend.push_back('{cyc + lat, o_addr});
    total++;
    if (pend.size() > MAX_OUT) begin
      bad++; $display("FAIL outstanding cyc=%0d got=%0d limit=%0d", cyc, pend.size(), MAX_OUT);
    end
    if (rst) begin
      model_reset();
    end else if (PCSrc_E) begin
      if (exp_vd) begin m_last_pc = mq[0].pc; m_last_pc4 = mq[0].pc + 32'd4; end
      take    = imem_rsp_valid && (m_out > 0);
      m_out   = m_out - int'(take);
      m_drop  = m_out;
      mq.delete();
      m_fetch = PCTarget_E & ~32'h3;
    end else begin
      if (exp_vd) begin
        m_last_pc  = mq[0].pc;
        m_last_pc4 = mq[0].pc + 32'd4;
        if (IF_ID_Write) void'(mq.pop_front());
      end
      if (imem_rsp_valid && m_out > 0) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].filled = 1'b1; mq[i].instr = imem_rsp_data; break;
            end
          end
        end
        m_out--;
      end
      if (exp_req && imem_req_ready) begin
        e.pc = m_fetch; e.instr = 32'h0; e.filled = 1'b0;
        mq.push_back(e);
        m_fetch += 32'd4;
        m_out++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; PCSrc_E = 1'b0; PCTarget_E = 32'h0; PC_Write = 1'b1;
    IF_ID_Write = 1'b1; imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    total++;
    if (o_req !== 1'b0 || o_vd !== 1'b0 || o_pcd !== 32'h0 || o_pc4 !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs got req=%0b vd=%0b pc=%h pc4=%h want 0", o_req, o_vd, o_pcd,
               o_pc4);
    end
  endtask

  task automatic test_stream();
    int          first_vd;
    logic [31:0] pops[$];
    lat = 1; rst = 1'b0; first_vd = 0;
    for (int k = 1; k <= 10; k++) begin
      run_cycle();
      if (o_vd && first_vd == 0) first_vd = k;
      if (o_vd) pops.push_back(o_pcd);
    end
    total++;
    if (first_vd != 3) begin
      bad++; $display("FAIL first_valid got=%0d want=3", first_vd);
    end
    total++;
    if (pops.size() < 3 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8) begin
      bad++; $display("FAIL pc_sequence got=%p want 0,4,8", pops);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    int          gaps;
    IF_ID_Write = 1'b0;
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      if (k == 0) pc0 = o_pcd;
      total++;
      if (o_pcd !== pc0) begin
        bad++; $display("FAIL stall_hold got=%h want=%h", o_pcd, pc0);
      end
    end
    total++;
    if (o_req !== 1'b0) begin
      bad++; $display("FAIL stall_full got req_valid=%0b want 0", o_req);
    end
    IF_ID_Write = 1'b1; gaps = 0;
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      if (!o_vd) gaps++;
    end
    total++;
    if (gaps != 0) begin
      bad++; $display("FAIL drain_gaps got=%0d want=0", gaps);
    end
  endtask

  task automatic redirect_and_check(input logic [31:0] target, input bit need_rsp);
    bit          seen_hs, seen_vd;
    logic [31:0] hs_addr, vd_pc, vd_ins;
    PCSrc_E = 1'b1; PCTarget_E = target;
    run_cycle();
    PCSrc_E = 1'b0;
    if (need_rsp && !imem_rsp_valid) $display("note: no response in redirect cycle");
    seen_hs = 1'b0; seen_vd = 1'b0;
    for (int k = 0; k < 20 && !seen_vd; k++) begin
      run_cycle();
      if (o_req && imem_req_ready && !seen_hs) begin seen_hs = 1'b1; hs_addr = o_addr; end
      if (o_vd) begin seen_vd = 1'b1; vd_pc = o_pcd; vd_ins = o_ins; end
    end
    total++;
    if (!seen_hs || hs_addr !== (target & ~32'h3)) begin
      bad++; $display("FAIL redirect_addr got=%h seen=%0b want=%h", hs_addr, seen_hs,
                      target & ~32'h3);
    end
    total++;
    if (!seen_vd || vd_pc !== (target & ~32'h3) || vd_ins !== instr_of(target & ~32'h3)) begin
      bad++; $display("FAIL redirect_first got pc=%h ins=%h seen=%0b want pc=%h", vd_pc,
                      vd_ins, seen_vd, target & ~32'h3);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    lat = 3; imem_req_ready = 1'b1; IF_ID_Write = 1'b1; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      run_cycle();
      ok = (pend.size() == 2);
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL setup_two_outstanding got=%0d want=2", pend.size());
    end
    redirect_and_check(32'h100, 1'b0);
  endtask

  task automatic test_redirect_rsp();
    bit ok;
    lat = 2; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      run_cycle();
      ok = (pend.size() == 2) && (pend[0].due <= cyc);
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL setup_rsp_collide got=%0d want=2", pend.size());
    end
    redirect_and_check(32'h203, 1'b1);
  endtask

  task automatic test_random();
    lat = 3;
    for (int k = 0; k < 400; k++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      IF_ID_Write    = ($urandom_range(0, 3) != 0);
      PC_Write       = ($urandom_range(0, 9) != 0);
      PCSrc_E        = ($urandom_range(0, 29) == 0);
      PCTarget_E     = $urandom & 32'h0000_FFFF;
      run_cycle();
    end
    PCSrc_E = 1'b0; PC_Write = 1'b1; IF_ID_Write = 1'b1; imem_req_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    lat = 1;
    for (int k = 0; k < 8; k++) run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run_cycle();
    total++;
    if (o_vd !== 1'b0 || o_ins !== NOP || o_pcd !== 32'h0 || o_pc4 !== 32'h0) begin
      bad++; $display("FAIL post_reset got vd=%0b ins=%h pc=%h pc4=%h", o_vd, o_ins, o_pcd,
                      o_pc4);
    end
    total++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      bad++; $display("FAIL restart_addr got req=%0b addr=%h want 1 00000000", o_req, o_addr);
    end
    for (int k = 0; k < 10; k++) run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; lat = 1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rsp();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 32: PC/address width.
- DAT_WIDTH, 32: instruction width.
- DEPTH, 4: queue entries, power of two.
- MAX_OUT, 2: maximum outstanding memory requests.
- RESET_PC, 32'h0: first fetch address.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 PCSrc_E  input  1  redirect request from execute.
REQ-005 PCTarget_E  input  ADDR_WIDTH  redirect target.
REQ-006 PC_Write  input  1  0 blocks new memory requests.
REQ-007 IF_ID_Write  input  1  decode accepts head entry when 1.
REQ-008 imem_req_valid  output  1  request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  ADDR_WIDTH  word-aligned fetch address.
REQ-011 imem_rsp_valid  input  1  in-order response strobe.
REQ-012 imem_rsp_data  input  DAT_WIDTH  fetched instruction.
REQ-013 valid_D  output  1  head entry holds a fetched instruction.
REQ-014 Ins_D / PC_D / PC_4D  output  DAT_WIDTH / ADDR_WIDTH / ADDR_WIDTH  head instruction, its PC, and PC+4.

Function
REQ-015 Each entry SHALL hold pc, instr, alloc and filled bits; entries SHALL be allocated at request acceptance in PC order and filled by responses in the same order.
REQ-016 imem_req_valid SHALL be 1 iff all of the following hold:
- not in reset;
- PC_Write=1;
- PCSrc_E=0;
- allocated entries < DEPTH;
- outstanding < MAX_OUT.
REQ-017 imem_req_addr SHALL equal the fetch PC; on a handshake (valid&ready), the fetch PC SHALL advance by 4 and outstanding SHALL increment.
REQ-018 A response with drop_cnt=0 SHALL write imem_rsp_data into the oldest allocated unfilled entry and decrement outstanding.
REQ-019 A response with drop_cnt>0 SHALL be discarded and SHALL decrement drop_cnt and outstanding.
REQ-020 valid_D SHALL equal the head entry's filled bit; Ins_D, PC_D and PC_4D SHALL come from head-entry registers, with zero combinational path from imem_rsp_*.
REQ-021 When valid_D=0, Ins_D SHALL be 32'h00000013 (NOP), and PC_D and PC_4D SHALL hold their last values.
REQ-022 Pop SHALL occur when valid_D=1 and IF_ID_Write=1; when IF_ID_Write=0, outputs SHALL hold unchanged.
REQ-023 Push and pop in the same cycle SHALL both take effect; the allocated count SHALL be unchanged.
REQ-024 PCSrc_E=1 SHALL have priority over pop, fill and issue, and SHALL do all of the following:
- clear all entries;
- set the fetch PC to {PCTarget_E[31:2],2'b00};
- set drop_cnt to outstanding, minus 1 if a response arrives that cycle.
REQ-025 The first request after a redirect SHALL be issued no earlier than the following cycle; first valid_D at the redirect target SHALL be at least 2 cycles after the redirect.
REQ-026 Latency SHALL be 1 cycle: with zero-latency memory (response the cycle after acceptance), valid_D SHALL rise the cycle after the response.
REQ-027 Pointers SHALL wrap modulo DEPTH; outstanding and drop_cnt SHALL be clog2(MAX_OUT+1) bits wide and SHALL never underflow.

Reset
REQ-028 While rst=1, the block SHALL hold:
- fetch PC = RESET_PC;
- entries cleared, pointers 0;
- outstanding = 0, drop_cnt = 0;
- imem_req_valid = 0, valid_D = 0;
- Ins_D = NOP, PC_D = 0, PC_4D = 0.
REQ-029 Reset asserted mid-transaction SHALL abandon in-flight requests; the memory is reset alongside, so responses arriving during reset SHALL be ignored.

Structure
REQ-030 Package ifq_pkg SHALL contain the NOP constant, the entry struct typedef (pc, instr, alloc, filled) and the default-parameter constants.
REQ-031 Entry array, pointers and count SHALL be one sub-module, ifq_ring; issue, drop and redirect control SHALL reside in ifetch_queue.

Verification
REQ-032 Reset release, always-ready memory, 1-cycle responses -> addresses 0,4,8,... issued; valid_D first at cycle 3; PC_D sequence 0,4,8.
REQ-033 IF_ID_Write=0 for 6 cycles -> queue fills to 4 and imem_req_valid drops; PC_D stays constant; after release, entries pop one per cycle with no gaps.
REQ-034 Redirect to 32'h100 with 2 requests outstanding -> both responses discarded; next request addr 32'h100; PC_D=32'h100 is the first valid output.
REQ-035 Redirect in the same cycle as a response, PCTarget_E=32'h203 -> that response discarded, drop_cnt=1, next request addr 32'h200.
REQ-036 imem_req_ready toggling and 3-cycle response latency -> never more than 2 outstanding; every instruction delivered in order with the correct PC.
REQ-037 rst pulsed mid-stream -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
